mux_sel_reg: RTL and testbench

//  Parametrised N-channel, WIDTH-bit registered operand/address selector with valid/ready handshakes.

---
 rtl/mux_sel_pkg.sv | 18 +
 rtl/mux_sel_reg_if.sv | 38 +++
 rtl/mux_sel_reg_rr_arbiter.sv | 30 +++
 rtl/mux_sel_reg.sv | 88 ++++++++
 tb/tb_mux_sel_reg.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sel_pkg.sv
// Shared constants and helpers for the registered channel selector.
// Channel slicing works on a zero-extended bus so it serves any WIDTH/NCH.
package mux_sel_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int BUS_MAX = 1024;
  localparam int CH_MAX  = 64;

  // Returns channel idx of a flattened bus of w-bit channels; callers cast down to w bits.
  function automatic logic [CH_MAX-1:0] ch_slice(input logic [BUS_MAX-1:0] bus,
                                                 input int unsigned       idx,
                                                 input int unsigned       w);
    ch_slice = CH_MAX'(bus >> (idx * w));
  endfunction

endpackage

// File: rtl/mux_sel_reg_if.sv
// Handshake bundle between data sources, the selector and its consumer.
// Optional MUX_SEL_REG_PARITY_EN adds out_parity.
interface mux_sel_reg_if #(
    parameter int WIDTH = 5,
    parameter int NCH   = 4
);
    localparam int SELW = $clog2(NCH);

    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic [NCH-1:0]       in_ready;
    logic                 mode;
    logic [SELW-1:0]      select;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready;
`ifdef MUX_SEL_REG_PARITY_EN
    logic                 out_parity;
`endif

    modport master (
        output in_data, in_valid, mode, select, out_ready,
`ifdef MUX_SEL_REG_PARITY_EN
        input  out_parity,
`endif
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, select, out_ready,
`ifdef MUX_SEL_REG_PARITY_EN
        output out_parity,
`endif
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/mux_sel_reg_rr_arbiter.sv
// Combinational round-robin find-first: scans ptr+1, ptr+2, ... with wrap.
// The lowest offset from ptr with a request wins.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [$clog2(NCH)-1:0] gnt_idx,
    output logic                   gnt_valid
);
    localparam int SELW = $clog2(NCH);

    logic [SELW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        // Walk from the farthest offset down so the nearest requester is written last.
        for (int k = NCH; k >= 1; k--) begin
            cand = SELW'((32'(ptr) + 32'(k)) % 32'(NCH));
            if (req[cand]) begin
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_reg.sv
// Registered NCH:1 selector with valid/ready handshakes, explicit or round-robin grant.
// Optional MUX_SEL_REG_PARITY_EN adds a registered even-parity output.
module mux_sel_reg
    import mux_sel_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int NCH   = 4
) (
    input logic          clk,
    input logic          rst,
    mux_sel_reg_if.slave bus
);
    localparam int SELW = $clog2(NCH);

    logic [SELW-1:0]  rr_ptr;
    logic [SELW-1:0]  arb_idx;
    logic             arb_valid;
    logic [SELW-1:0]  gnt_idx;
    logic             gnt_valid;
    logic             load;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_data_q;
    logic [SELW-1:0]  out_ch_q;
    logic             out_valid_q;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    assign load = !out_valid_q || bus.out_ready;

    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        if (bus.mode == MODE_RR) begin
            gnt_idx   = arb_idx;
            gnt_valid = arb_valid;
        end else if (32'(bus.select) < 32'(NCH)) begin
            gnt_idx   = bus.select;
            gnt_valid = bus.in_valid[bus.select];
        end
    end

    assign xfer     = load && gnt_valid;
    assign sel_data = WIDTH'(ch_slice(BUS_MAX'(bus.in_data), 32'(gnt_idx), WIDTH));

    always_comb begin
        bus.in_ready = '0;
        if (xfer) bus.in_ready[gnt_idx] = 1'b1;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr      <= SELW'(NCH - 1);
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_ch_q    <= gnt_idx;
            if (bus.mode == MODE_RR) rr_ptr <= gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

`ifdef MUX_SEL_REG_PARITY_EN
    logic out_parity_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       out_parity_q <= 1'b0;
        else if (xfer) out_parity_q <= ^sel_data;
    end

    assign bus.out_parity = out_parity_q;
`endif

endmodule

// File: tb/tb_mux_sel_reg.sv
// Self-checking bench for mux_sel_reg: vector table, directed corner cases,
// and randomized traffic against a behavioural model (NCH=4 and NCH=3 instances).
module tb_mux_sel_reg;
    import mux_sel_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_sel_reg_if #(.WIDTH(5), .NCH(4)) b4 ();
    mux_sel_reg_if #(.WIDTH(5), .NCH(3)) b3 ();

    mux_sel_reg #(.WIDTH(5), .NCH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mux_sel_reg #(.WIDTH(5), .NCH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    // Reference model state for the NCH=4 instance.
    logic       m_valid;
    logic [4:0] m_data;
    int         m_ch;
    int         m_ptr;
    logic       m_par;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [4:0] od;
        logic [1:0] och;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec-level grant rule: -1 means no channel is granted.
    function automatic int exp_grant(input logic md, input int sel, input logic [3:0] v,
                                     input int ptr, input int nch);
        if (md == MODE_SEL) return (sel < nch && v[sel]) ? sel : -1;
        for (int k = 1; k <= nch; k++) begin
            int c = (ptr + k) % nch;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
        m_ptr   = 3;
        m_par   = 1'b0;
    endtask

    task automatic set_data4(input logic [4:0] d0, d1, d2, d3);
        b4.in_data = {d3, d2, d1, d0};
    endtask

    // One model-checked cycle of the NCH=4 instance with whatever inputs are currently driven.
    task automatic model_cycle(input string tag);
        logic       md, ordy, ld;
        logic [3:0] v, exp_rdy;
        logic [19:0] d;
        int         sel, g;
        #1;
        md = b4.mode; sel = int'(b4.select); v = b4.in_valid; d = b4.in_data; ordy = b4.out_ready;
        ld = !m_valid || ordy;
        g  = exp_grant(md, sel, v, m_ptr, 4);
        exp_rdy = (ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        check({tag, ".in_ready"}, 32'(b4.in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        if (ld && g >= 0) begin
            m_valid = 1'b1;
            m_data  = d[g*5 +: 5];
            m_par   = ^d[g*5 +: 5];
            m_ch    = g;
            if (md == MODE_RR) m_ptr = g;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        check({tag, ".out_valid"}, 32'(b4.out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(b4.out_data),  32'(m_data));
        check({tag, ".out_ch"},    32'(b4.out_ch),    32'(m_ch));
`ifdef MUX_SEL_REG_PARITY_EN
        check({tag, ".out_parity"}, 32'(b4.out_parity), 32'(m_par));
`endif
    endtask

    task automatic drive4(input logic md, input logic [1:0] sel, input logic [3:0] v, input logic ordy);
        b4.mode = md; b4.select = sel; b4.in_valid = v; b4.out_ready = ordy;
    endtask

    initial begin
        b4.in_data = '0; b4.in_valid = '0; b4.mode = MODE_SEL; b4.select = '0; b4.out_ready = 1'b0;
        b3.in_data = '0; b3.in_valid = '0; b3.mode = MODE_SEL; b3.select = '0; b3.out_ready = 1'b0;

        vecs[0] = '{MODE_SEL, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 5'h15, 2'd2};
        vecs[1] = '{MODE_SEL, 2'd3, 4'b0111, 1'b1, 4'b0000, 1'b0, 5'h15, 2'd2};
        vecs[2] = '{MODE_SEL, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 5'h01, 2'd0};
        vecs[3] = '{MODE_SEL, 2'd1, 4'b1111, 1'b0, 4'b0000, 1'b1, 5'h01, 2'd0};
        vecs[4] = '{MODE_SEL, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 5'h0B, 2'd1};
        vecs[5] = '{MODE_RR,  2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 5'h01, 2'd0};
        vecs[6] = '{MODE_RR,  2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 5'h0B, 2'd1};
        vecs[7] = '{MODE_RR,  2'd0, 4'b1000, 1'b0, 4'b0000, 1'b1, 5'h0B, 2'd1};
        vecs[8] = '{MODE_RR,  2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 5'h1F, 2'd3};
        vecs[9] = '{MODE_RR,  2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 5'h1F, 2'd3};

        do_reset();
        check("reset.out_valid", 32'(b4.out_valid), 32'd0);
        check("reset.out_data",  32'(b4.out_data),  32'd0);
        check("reset.out_ch",    32'(b4.out_ch),    32'd0);

        // Vector table: explicit select, hold, drain and round-robin from reset.
        set_data4(5'h01, 5'h0B, 5'h15, 5'h1F);
        for (int i = 0; i < 10; i++) begin
            drive4(vecs[i].mode, vecs[i].sel, vecs[i].valid, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d.in_ready", i), 32'(b4.in_ready), 32'(vecs[i].rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.out_valid", i), 32'(b4.out_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d.out_data", i),  32'(b4.out_data),  32'(vecs[i].od));
            check($sformatf("vec%0d.out_ch", i),    32'(b4.out_ch),    32'(vecs[i].och));
        end

        // Round-robin order with all channels requesting, then only 1 and 3.
        do_reset();
        drive4(MODE_RR, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr_all%0d.out_ch", i), 32'(b4.out_ch), 32'(i % 4));
        end
        do_reset();
        drive4(MODE_RR, 2'd0, 4'b1010, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr_13_%0d.out_ch", i), 32'(b4.out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Backpressure: 5'h0A held for three cycles, then drained and replaced with no bubble.
        do_reset();
        set_data4(5'h0A, 5'h11, 5'h15, 5'h1F);
        drive4(MODE_SEL, 2'd0, 4'b1111, 1'b0);
        @(posedge clk);
        #1;
        check("bp.load", 32'(b4.out_data), 32'h0A);
        drive4(MODE_SEL, 2'd1, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp%0d.in_ready", i), 32'(b4.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("bp%0d.out_data", i), 32'(b4.out_data), 32'h0A);
        end
        b4.out_ready = 1'b1;
        #1;
        check("bp_drain.in_ready", 32'(b4.in_ready), 32'b0010);
        @(posedge clk);
        #1;
        check("bp_drain.out_data",  32'(b4.out_data),  32'h11);
        check("bp_drain.out_valid", 32'(b4.out_valid), 32'd1);

        // Asynchronous reset mid-stream, sampled before any clock edge.
        b4.out_ready = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check("async_rst.out_valid", 32'(b4.out_valid), 32'd0);
        check("async_rst.out_data",  32'(b4.out_data),  32'd0);
        check("async_rst.out_ch",    32'(b4.out_ch),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // NCH=3: out-of-range select never grants; mode switch leaves the held word alone.
        b4.in_valid = '0;
        do_reset();
        b3.in_data = {5'h1C, 5'h0C, 5'h03};
        b3.mode = MODE_SEL; b3.select = 2'd3; b3.in_valid = 3'b111; b3.out_ready = 1'b1;
        #1;
        check("n3_oor.in_ready", 32'(b3.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("n3_oor.out_valid", 32'(b3.out_valid), 32'd0);
        b3.select = 2'd1; b3.out_ready = 1'b0;
        #1;
        check("n3_sel1.in_ready", 32'(b3.in_ready), 32'b010);
        @(posedge clk);
        #1;
        check("n3_sel1.out_data", 32'(b3.out_data), 32'h0C);
        b3.mode = MODE_RR;
        for (int i = 0; i < 2; i++) begin
            #1;
            check($sformatf("n3_hold%0d.in_ready", i), 32'(b3.in_ready), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("n3_hold%0d.out_data", i), 32'(b3.out_data), 32'h0C);
        end
        b3.out_ready = 1'b1;
        #1;
        check("n3_rr.in_ready", 32'(b3.in_ready), 32'b001);
        @(posedge clk);
        #1;
        check("n3_rr.out_data", 32'(b3.out_data), 32'h03);
        check("n3_rr.out_ch",   32'(b3.out_ch),   32'd0);
        b3.in_valid = '0;

`ifdef MUX_SEL_REG_PARITY_EN
        do_reset();
        check("par.reset", 32'(b4.out_parity), 32'd0);
        set_data4(5'b10110, 5'b00011, 5'h00, 5'h00);
        drive4(MODE_SEL, 2'd0, 4'b1111, 1'b1);
        @(posedge clk);
        #1;
        check("par.10110", 32'(b4.out_parity), 32'd1);
        b4.select = 2'd1;
        @(posedge clk);
        #1;
        check("par.00011", 32'(b4.out_parity), 32'd0);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            b4.in_data   = 20'($urandom);
            b4.in_valid  = 4'($urandom);
            b4.mode      = ($urandom_range(0, 3) != 0) ? MODE_RR : MODE_SEL;
            b4.select    = 2'($urandom);
            b4.out_ready = ($urandom_range(0, 3) != 0);
            model_cycle($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
